// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter
// Round-robin arbiter that shares one 3-to-8 active-low select decoder
// (enable G high, GA/GB low) among eight requesters. All decoder-facing
// outputs are registered, so at most one decoder output is ever low, and
// one IDLE cycle always separates consecutive grants (break-before-make).
// A hold timer bounds the length of any single grant.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (priority over all inputs)
//   en         in   arbitration enable; low blocks new grants only
//   req[7:0]   in   per-requester request, index i maps to decoder Y[i]
//   release_i  in   current owner is done (looked at only while granting)
//   A[2:0]     out  decoder select = granted index
//   G          out  decoder enable, active-high
//   GA, GB     out  decoder enables, active-low
//   gnt_valid  out  grant active (same as G)
//   timeout    out  one-cycle pulse after a grant ended by the hold timer
module rr_dec_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       release_i,
    output logic [2:0] A,
    output logic       G,
    output logic       GA,
    output logic       GB,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_ptr;
    logic [2:0]         r_a;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_g;
    logic               r_ga;
    logic               r_gb;
    logic               r_timeout;

    logic [15:0]        w_dbl;
    logic [7:0]         w_rot;
    logic [2:0]         w_off;
    logic [2:0]         w_win;
    logic               w_start;
    logic               w_rel;
    logic               w_drop;
    logic               w_hold;
    logic               w_exit;

    logic [2:0]         w_ptr_nxt;
    logic [2:0]         w_a_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_g_nxt;
    logic               w_to_nxt;

    // Rotate req so that the pointer position lands at bit 0; the first set
    // bit of the rotated vector is then the offset of the winner from ptr.
    assign w_dbl = {req, req} >> r_ptr;
    assign w_rot = w_dbl[7:0];

    // Lowest set bit of the rotated request vector (descending scan so the
    // last write is the lowest index).
    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            w_off = w_rot[i] ? 3'(i) : w_off;
        end
    end

    assign w_win   = r_ptr + w_off;
    assign w_start = en & (|req);

    // Grant exit conditions: release, requester drop, hold timer expiry.
    assign w_rel  = release_i;
    assign w_drop = ~req[r_a];
    assign w_hold = (r_cnt == CNT_W'(HOLD_MAX - 1));
    assign w_exit = w_rel | w_drop | w_hold;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_start ? ST_GRANT : ST_IDLE;
            ST_GRANT: w_state_nxt = w_exit  ? ST_IDLE  : ST_GRANT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the pointer, select, hold counter and output pins.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_a_nxt   = r_a;
        w_cnt_nxt = r_cnt;
        w_to_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_a_nxt   = w_win;
                    w_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_a_nxt   = r_a;
                end
            end
            ST_GRANT: begin
                if (w_exit) begin
                    // The finished owner drops to lowest priority.
                    w_ptr_nxt = r_a + 3'd1;
                    w_cnt_nxt = {CNT_W{1'b0}};
                    // Timer-only exits are flagged; release/drop win ties.
                    w_to_nxt  = w_hold & ~w_rel & ~w_drop;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_ptr_nxt = r_ptr;
            end
        endcase
        w_g_nxt = (w_state_nxt == ST_GRANT);
    end

    // Datapath and output registers; enables always move as one group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 3'd0;
            r_a       <= 3'd0;
            r_cnt     <= {CNT_W{1'b0}};
            r_g       <= 1'b0;
            r_ga      <= 1'b1;
            r_gb      <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_a       <= w_a_nxt;
            r_cnt     <= w_cnt_nxt;
            r_g       <= w_g_nxt;
            r_ga      <= ~w_g_nxt;
            r_gb      <= ~w_g_nxt;
            r_timeout <= w_to_nxt;
        end
    end

    assign A         = r_a;
    assign G         = r_g;
    assign GA        = r_ga;
    assign GB        = r_gb;
    assign gnt_valid = r_g;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
module tb_rr_dec_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       release_i;
    logic [2:0] A;
    logic       G, GA, GB, gnt_valid, timeout;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model state: who owns the decoder and for how many cycles.
    bit m_busy;
    int m_a;
    int m_ptr;
    int m_len;
    bit m_to;

    rr_dec_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .release_i(release_i),
        .A(A), .G(G), .GA(GA), .GB(GB), .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model evaluated on each rising edge from the inputs.
    always @(posedge clk) begin
        bit found;
        if (rst) begin
            m_busy = 0; m_a = 0; m_ptr = 0; m_len = 0; m_to = 0;
        end else if (m_busy) begin
            if (release_i || !req[m_a] || m_len == HOLD) begin
                m_to   = (m_len == HOLD) && !release_i && req[m_a];
                m_busy = 0;
                m_ptr  = (m_a + 1) % 8;
            end else begin
                m_len++;
                m_to = 0;
            end
        end else begin
            m_to = 0;
            if (en && req != 8'h00) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && req[(m_ptr + k) % 8]) begin
                        m_a   = (m_ptr + k) % 8;
                        found = 1;
                    end
                end
                m_busy = 1;
                m_len  = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("mdl_A", A, m_a);
            chk("mdl_G", G, m_busy);
            chk("mdl_GA", GA, !m_busy);
            chk("mdl_GB", GB, !m_busy);
            chk("mdl_gnt_valid", gnt_valid, m_busy);
            chk("mdl_timeout", timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_G"}, G, 0);
        chk({tag, "_GA"}, GA, 1);
        chk({tag, "_GB"}, GB, 1);
        chk({tag, "_gnt_valid"}, gnt_valid, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; release_i = 1'b0;
        tick(); tick();
        @(negedge clk); rst = 1'b0; chk_on = 1'b1;
        check_reset_vals("rst0");

        // First grant, then reset in the middle of it.
        req = 8'h01; en = 1'b1;
        tick();
        chk("g0_A", A, 0); chk("g0_G", G, 1);
        @(negedge clk); rst = 1'b1;
        tick();
        check_reset_vals("rst_mid");
        tick();
        @(negedge clk); rst = 1'b0;
        tick();
        chk("post_rst_A", A, 0); chk("post_rst_G", G, 1);
        @(negedge clk); req = 8'h00;
        tick();
        chk("drop0_G", G, 0); chk("drop0_to", timeout, 0);

        // Rotation with all requesters active from a fresh pointer.
        @(negedge clk); rst = 1'b1; req = 8'hFF;
        tick();
        @(negedge clk); rst = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("rot_A", A, i % 8);
            chk("rot_G", G, 1);
            @(negedge clk); release_i = 1'b1;
            tick();
            chk("rot_dead", G, 0);
            @(negedge clk); release_i = 1'b0;
            if (i < 8) tick();
        end

        // Pointer skip around a just-served requester.
        req = 8'h20;
        tick();
        chk("skip5_A", A, 5); chk("skip5_G", G, 1);
        @(negedge clk); release_i = 1'b1; req = 8'h21;
        tick();
        chk("skip_dead", G, 0);
        @(negedge clk); release_i = 1'b0;
        tick();
        chk("skip0_A", A, 0); chk("skip0_G", G, 1);
        @(negedge clk); release_i = 1'b1;
        tick();
        @(negedge clk); release_i = 1'b0;
        tick();
        chk("skip5b_A", A, 5); chk("skip5b_G", G, 1);

        // Hold timer expiry.
        @(negedge clk); release_i = 1'b1; req = 8'h08;
        tick();
        @(negedge clk); release_i = 1'b0;
        tick();
        chk("to_A1", A, 3); chk("to_G1", G, 1);
        for (int j = 2; j <= HOLD; j++) begin
            tick();
            chk("to_A", A, 3); chk("to_G", G, 1); chk("to_nopulse", timeout, 0);
        end
        tick();
        chk("to_G_off", G, 0); chk("to_pulse", timeout, 1);
        tick();
        chk("to_regrant_A", A, 3); chk("to_regrant_G", G, 1);
        chk("to_pulse_end", timeout, 0);

        // Requester drop ends the grant without a timeout.
        @(negedge clk); req = 8'h04;
        tick();
        chk("drop3_G", G, 0); chk("drop3_to", timeout, 0);
        tick();
        chk("g2_A", A, 2); chk("g2_G", G, 1);
        @(negedge clk); req = 8'h00;
        tick();
        chk("drop2_G", G, 0); chk("drop2_to", timeout, 0);

        // Release on the final hold cycle beats the timer.
        @(negedge clk); req = 8'h04;
        tick();
        chk("rl_A", A, 2); chk("rl_G", G, 1);
        tick(); tick(); tick();
        chk("rl_G4", G, 1);
        @(negedge clk); release_i = 1'b1;
        tick();
        chk("rl_G_off", G, 0); chk("rl_to", timeout, 0);
        @(negedge clk); release_i = 1'b0; req = 8'h00;

        // Enable gating.
        en = 1'b0; req = 8'h80;
        repeat (6) begin
            tick();
            chk("en0_G", G, 0);
        end
        @(negedge clk); en = 1'b1;
        tick();
        chk("en1_A", A, 7); chk("en1_G", G, 1);
        @(negedge clk); en = 1'b0;
        tick(); tick();
        chk("en_mid_A", A, 7); chk("en_mid_G", G, 1);
        @(negedge clk); release_i = 1'b1;
        tick();
        chk("en_rel_G", G, 0);
        @(negedge clk); release_i = 1'b0;
        repeat (4) begin
            tick();
            chk("en0b_G", G, 0);
        end
        @(negedge clk); en = 1'b1;
        tick();
        chk("en1b_A", A, 7); chk("en1b_G", G, 1);

        @(negedge clk); req = 8'h00;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
